// File: rtl/uart_tx_sched.sv
// Two-source UART TX frame scheduler: resp-priority arbitration with a
// tlm starvation guard, XOR checksum append and optional inter-frame gap.
module uart_tx_sched #(
  parameter int MAX_STREAK = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resp_req,
  input  logic [39:0] resp_frame,
  output logic        resp_ack,
  input  logic        tlm_req,
  input  logic [39:0] tlm_frame,
  output logic        tlm_ack,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        cur_src,
  output logic [15:0] resp_frames,
  output logic [15:0] tlm_frames
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_STREAK);
  localparam logic [7:0] GAP_N = 8'(GAP_CYCLES);

  state_t      state, state_d;
  logic [39:0] frame_q, frame_d;
  logic [7:0]  chk_q, chk_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [3:0]  streak_q, streak_d;
  logic        resp_ack_d, tlm_ack_d;
  logic        tx_valid_d, busy_d, cur_src_d;
  logic [7:0]  tx_data_d;
  logic [15:0] resp_frames_d, tlm_frames_d;
  logic        pick_tlm;
  logic [39:0] sel;

  function automatic logic [7:0] xor5(
    input logic [39:0] f
  );
    return f[7:0] ^ f[15:8] ^ f[23:16]
         ^ f[31:24] ^ f[39:32];
  endfunction

  function automatic logic [7:0] byte_at(
    input logic [39:0] f,
    input logic [7:0]  c,
    input logic [2:0]  i
  );
    logic [7:0] b;
    unique case (i)
      3'd0:    b = f[7:0];
      3'd1:    b = f[15:8];
      3'd2:    b = f[23:16];
      3'd3:    b = f[31:24];
      3'd4:    b = f[39:32];
      default: b = c;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d       = state;
    frame_d       = frame_q;
    chk_d         = chk_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    streak_d      = streak_q;
    resp_ack_d    = 1'b0;
    tlm_ack_d     = 1'b0;
    tx_valid_d    = tx_valid;
    tx_data_d     = tx_data;
    busy_d        = busy;
    cur_src_d     = cur_src;
    resp_frames_d = resp_frames;
    tlm_frames_d  = tlm_frames;
    pick_tlm      = tlm_req &&
                    (!resp_req || streak_q == MAX_S);
    sel           = pick_tlm ? tlm_frame : resp_frame;
    unique case (state)
      IDLE: begin
        if (resp_req || tlm_req) begin
          frame_d    = sel;
          chk_d      = xor5(sel);
          cur_src_d  = pick_tlm;
          resp_ack_d = !pick_tlm;
          tlm_ack_d  = pick_tlm;
          tx_valid_d = 1'b1;
          tx_data_d  = sel[7:0];
          busy_d     = 1'b1;
          idx_d      = 3'd0;
          state_d    = SEND;
          if (pick_tlm)
            streak_d = 4'd0;
          else if (streak_q != MAX_S)
            streak_d = streak_q + 4'd1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q != 3'd5) begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = byte_at(frame_q, chk_q,
                                idx_q + 3'd1);
          end else begin
            idx_d      = 3'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            if (cur_src)
              tlm_frames_d = tlm_frames + 16'd1;
            else
              resp_frames_d = resp_frames + 16'd1;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = GAP;
              gap_d   = GAP_N;
            end
          end
        end
      end
      GAP: begin
        // Count reaches 1 on the last gap cycle.
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frame_q     <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      streak_q    <= '0;
      resp_ack    <= 1'b0;
      tlm_ack     <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      cur_src     <= 1'b0;
      resp_frames <= '0;
      tlm_frames  <= '0;
    end else begin
      state       <= state_d;
      frame_q     <= frame_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      streak_q    <= streak_d;
      resp_ack    <= resp_ack_d;
      tlm_ack     <= tlm_ack_d;
      tx_valid    <= tx_valid_d;
      tx_data     <= tx_data_d;
      busy        <= busy_d;
      cur_src     <= cur_src_d;
      resp_frames <= resp_frames_d;
      tlm_frames  <= tlm_frames_d;
    end
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Frame-level scheduler sharing the single UART TX byte port between two frame sources: command responses (resp) and unsolicited telemetry (tlm). Each source offers a 5-byte frame header/payload. The block grants one source, appends the XOR checksum byte and serializes the 6-byte frame onto the tx_valid/tx_data/tx_ready interface. Arbitration is fixed-priority for resp, with a starvation guard for tlm and an optional inter-frame gap.

Parameters:
MAX_STREAK, 4, consecutive resp grants allowed while tlm is pending before tlm must win (1..15)
GAP_CYCLES, 0, idle cycles inserted after each frame's last byte is accepted (0..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
resp_req  input  1  resp source has a frame; held until resp_ack
resp_frame  input  40  resp frame bytes; [7:0]=byte0 (SOF) ... [39:32]=byte4
resp_ack  output  1  one-cycle pulse: resp frame latched
tlm_req  input  1  tlm source has a frame; held until tlm_ack
tlm_frame  input  40  tlm frame bytes, same packing
tlm_ack  output  1  one-cycle pulse: tlm frame latched
tx_valid  output  1  byte on tx_data valid
tx_data  output  8  byte to UART TX
tx_ready  input  1  UART TX accepts byte when tx_valid && tx_ready at rising edge
busy  output  1  high in SEND or GAP
cur_src  output  1  source of frame in flight: 0=resp, 1=tlm; holds last value when idle
resp_frames  output  16  count of completed resp frames, wraps at 0xFFFF
tlm_frames  output  16  count of completed tlm frames, wraps

Behaviour:
- Reset values: resp_ack=0, tlm_ack=0, tx_valid=0, tx_data=0x00, busy=0, cur_src=0, resp_frames=0, tlm_frames=0. Internal: state=IDLE, streak=0, byte index=0, gap counter=0.
- States: IDLE, SEND, GAP.
- IDLE, evaluated each edge:
  - No req: stay.
  - Only resp_req: grant resp.
  - Only tlm_req: grant tlm.
  - Both: grant tlm if streak==MAX_STREAK, else resp.
- Grant at edge N:
  - Latch the chosen 40-bit frame and compute chk = b0^b1^b2^b3^b4.
  - Set cur_src and the matching ack (high during cycle N+1 only).
  - tx_valid=1, tx_data=b0, busy=1; go to SEND with index=0. First byte is visible one cycle after req is sampled.
- Streak counter:
  - resp grant: streak+1, saturating at MAX_STREAK.
  - tlm grant: clear to 0.
  - resp granted with streak already saturated and no tlm pending: streak stays at MAX_STREAK.
- SEND:
  - tx_data/tx_valid held stable while tx_ready=0.
  - On edge with tx_ready=1 and index<5: index+1, tx_data = next byte (index 5 = chk).
  - On edge with tx_ready=1 and index==5:
    - tx_valid=0, tx_data=0x00.
    - Increment the counter for cur_src.
    - If GAP_CYCLES==0: go to IDLE, busy=0.
    - Else: go to GAP with counter=GAP_CYCLES.
  - No back-to-back frame without an IDLE cycle: minimum 7 cycles per frame with tx_ready tied high.
- GAP: counter decrements each edge; at 1 -> IDLE, busy=0. Exactly GAP_CYCLES cycles with busy=1 and tx_valid=0.
- req/frame are sampled only in IDLE. Changes to req or frame during SEND/GAP are ignored. A source still asserting req in the cycle after its ack is treated as a new frame at the next IDLE.
- The latched frame is immune to source changes after the grant.
- rst asserted mid-frame: all outputs return to reset values at that edge and the frame is abandoned. A pending ack pulse is cleared, no counter increment, streak=0.

Test Plan:
- Single resp: resp_frame=40'h00_16_01_00_5A, resp_req held, tx_ready=1 -> resp_ack one cycle; tx bytes 5A 00 01 16 00 4D on 6 consecutive cycles; resp_frames=1, busy low after.
- Backpressure: same frame, tx_ready toggled 1,0,0,1... -> each byte held stable while tx_ready=0; no byte lost or duplicated; checksum still 0x4D.
- Starvation guard, MAX_STREAK=4: resp_req and tlm_req held continuously -> grant order resp,resp,resp,resp,tlm,resp..., cur_src matching; tlm_frames=1 after 5th frame.
- Simultaneous req after reset: both asserted in first IDLE cycle -> resp wins (streak=0), tlm granted only after resp frame completes.
- Gap, GAP_CYCLES=3: two queued tlm frames -> exactly 3 cycles busy=1/tx_valid=0 after last byte of frame 1, then 1 IDLE cycle, then byte0 of frame 2.
- Reset mid-frame: rst during byte 3 -> tx_valid=0, counters=0, busy=0 on that edge; re-asserted req after rst releases sends full frame from byte0.
